// File: rtl/ctrl_pkg.sv
// ctrl_pkg: encodings and control-word type shared by the control_unit decode stage.
package ctrl_pkg;
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;
    localparam logic [5:0] OP_ADDIU   = 6'b001001;
    localparam logic [5:0] OP_SLTI    = 6'b001010;
    localparam logic [5:0] OP_SLTIU   = 6'b001011;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;

    localparam logic [5:0] F_SLL     = 6'b000000;
    localparam logic [5:0] F_SRL     = 6'b000010;
    localparam logic [5:0] F_SRA     = 6'b000011;
    localparam logic [5:0] F_JR      = 6'b001000;
    localparam logic [5:0] F_SYSCALL = 6'b001100;
    localparam logic [5:0] F_MFHI    = 6'b010000;
    localparam logic [5:0] F_MFLO    = 6'b010010;
    localparam logic [5:0] F_MULT    = 6'b011000;
    localparam logic [5:0] F_ADDU    = 6'b100001;
    localparam logic [5:0] F_SUBU    = 6'b100011;
    localparam logic [5:0] F_AND     = 6'b100100;
    localparam logic [5:0] F_OR      = 6'b100101;
    localparam logic [5:0] F_XOR     = 6'b100110;
    localparam logic [5:0] F_NOR     = 6'b100111;
    localparam logic [5:0] F_SLT     = 6'b101010;
    localparam logic [5:0] F_SLTU    = 6'b101011;

    localparam logic [4:0] RT_BLTZ = 5'b00000;
    localparam logic [4:0] RT_BGEZ = 5'b00001;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_AND  = 5'd2;
    localparam logic [4:0] ALU_OR   = 5'd3;
    localparam logic [4:0] ALU_XOR  = 5'd4;
    localparam logic [4:0] ALU_NOR  = 5'd5;
    localparam logic [4:0] ALU_SLT  = 5'd6;
    localparam logic [4:0] ALU_SLTU = 5'd7;
    localparam logic [4:0] ALU_SLL  = 5'd8;
    localparam logic [4:0] ALU_SRL  = 5'd9;
    localparam logic [4:0] ALU_SRA  = 5'd10;
    localparam logic [4:0] ALU_MULT = 5'd11;

    localparam logic [3:0] BCU_NONE = 4'd0;
    localparam logic [3:0] BCU_EQ   = 4'd1;
    localparam logic [3:0] BCU_NE   = 4'd2;
    localparam logic [3:0] BCU_LTZ  = 4'd3;
    localparam logic [3:0] BCU_GEZ  = 4'd4;
    localparam logic [3:0] BCU_LEZ  = 4'd5;
    localparam logic [3:0] BCU_GTZ  = 4'd6;

    localparam logic [1:0] JMP_NONE = 2'b00;
    localparam logic [1:0] JMP_ABS  = 2'b01;
    localparam logic [1:0] JMP_REG  = 2'b10;

    localparam logic [1:0] MHL_NONE = 2'b00;
    localparam logic [1:0] MHL_HI   = 2'b01;
    localparam logic [1:0] MHL_LO   = 2'b10;
    localparam logic [1:0] MHL_WR   = 2'b11;

    typedef struct packed {
        logic       load_upper;
        logic [1:0] jump;
        logic       jal;
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic [4:0] alu_control;
        logic       alu_src;
        logic       reg_dst;
        logic       branch;
        logic [3:0] bcu_control;
        logic       syscall;
        logic [1:0] move_hi_lo;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // register-register ALU op writing rd
    function automatic ctrl_t rr_word(input logic [4:0] alu);
        ctrl_t c = CTRL_NOP;
        c.reg_write   = 1'b1;
        c.reg_dst     = 1'b1;
        c.alu_control = alu;
        return c;
    endfunction

    function automatic ctrl_t ri_word(input logic [4:0] alu);
        ctrl_t c = CTRL_NOP;
        c.reg_write   = 1'b1;
        c.alu_src     = 1'b1;
        c.alu_control = alu;
        return c;
    endfunction

    function automatic ctrl_t br_word(input logic [3:0] bcu, input logic [4:0] alu);
        ctrl_t c = CTRL_NOP;
        c.branch      = 1'b1;
        c.bcu_control = bcu;
        c.alu_control = alu;
        return c;
    endfunction
endpackage

// File: rtl/control_decode.sv
// control_decode: combinational opcode/funct/rt decoder; HI/LO ops only with CONTROL_UNIT_HILO_EN.
module control_decode
    import ctrl_pkg::*;
(
    input  logic [5:0] op_code,
    input  logic [5:0] funct_code,
    input  logic [4:0] rt,
    output ctrl_t      ctrl
);
    always_comb begin
        ctrl = CTRL_NOP;
        case (op_code)
            OP_SPECIAL: case (funct_code)
                F_ADDU:    ctrl = rr_word(ALU_ADD);
                F_SUBU:    ctrl = rr_word(ALU_SUB);
                F_AND:     ctrl = rr_word(ALU_AND);
                F_OR:      ctrl = rr_word(ALU_OR);
                F_XOR:     ctrl = rr_word(ALU_XOR);
                F_NOR:     ctrl = rr_word(ALU_NOR);
                F_SLT:     ctrl = rr_word(ALU_SLT);
                F_SLTU:    ctrl = rr_word(ALU_SLTU);
                F_SLL:     ctrl = rr_word(ALU_SLL);
                F_SRL:     ctrl = rr_word(ALU_SRL);
                F_SRA:     ctrl = rr_word(ALU_SRA);
                F_JR:      ctrl.jump = JMP_REG;
                F_SYSCALL: ctrl.syscall = 1'b1;
`ifdef CONTROL_UNIT_HILO_EN
                F_MULT: begin
                    ctrl.alu_control = ALU_MULT;
                    ctrl.move_hi_lo  = MHL_WR;
                end
                F_MFHI: begin
                    ctrl = rr_word(ALU_ADD);
                    ctrl.move_hi_lo = MHL_HI;
                end
                F_MFLO: begin
                    ctrl = rr_word(ALU_ADD);
                    ctrl.move_hi_lo = MHL_LO;
                end
`endif
                default: ctrl = CTRL_NOP;
            endcase
            OP_REGIMM: ctrl = (rt == RT_BLTZ) ? br_word(BCU_LTZ, ALU_ADD) :
                              (rt == RT_BGEZ) ? br_word(BCU_GEZ, ALU_ADD) : CTRL_NOP;
            OP_ADDIU: ctrl = ri_word(ALU_ADD);
            OP_ANDI:  ctrl = ri_word(ALU_AND);
            OP_ORI:   ctrl = ri_word(ALU_OR);
            OP_XORI:  ctrl = ri_word(ALU_XOR);
            OP_SLTI:  ctrl = ri_word(ALU_SLT);
            OP_SLTIU: ctrl = ri_word(ALU_SLTU);
            OP_LUI: begin
                ctrl = ri_word(ALU_ADD);
                ctrl.load_upper = 1'b1;
            end
            OP_LW: begin
                ctrl = ri_word(ALU_ADD);
                ctrl.mem_to_reg = 1'b1;
            end
            OP_SW: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
            end
            OP_J: ctrl.jump = JMP_ABS;
            OP_JAL: begin
                ctrl.jump      = JMP_ABS;
                ctrl.jal       = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            OP_BEQ:  ctrl = br_word(BCU_EQ, ALU_SUB);
            OP_BNE:  ctrl = br_word(BCU_NE, ALU_SUB);
            OP_BLEZ: ctrl = br_word(BCU_LEZ, ALU_ADD);
            OP_BGTZ: ctrl = br_word(BCU_GTZ, ALU_ADD);
            default: ctrl = CTRL_NOP;
        endcase
    end
endmodule

// File: rtl/control_unit.sv
// control_unit: decode-stage control word registered into ID/EX with stall/flush.
// Optional HI/LO decode enabled by defining CONTROL_UNIT_HILO_EN.
module control_unit
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       stall,
    input  logic       flush,
    input  logic [5:0] op_code,
    input  logic [5:0] funct_code,
    input  logic [4:0] rt,
    output logic       load_upper,
    output logic [1:0] jump,
    output logic       jal,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       mem_write,
    output logic [4:0] alu_control,
    output logic       alu_src,
    output logic       reg_dst,
    output logic       branch,
    output logic [3:0] bcu_control,
    output logic       syscall,
    output logic [1:0] move_hi_lo
);
    ctrl_t dec, ctrl_d, ctrl_q;

    control_decode u_decode (
        .op_code    (op_code),
        .funct_code (funct_code),
        .rt         (rt),
        .ctrl       (dec)
    );

    // flush wins over stall
    assign ctrl_d = flush ? CTRL_NOP : stall ? ctrl_q : dec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ctrl_q <= CTRL_NOP;
        else
            ctrl_q <= ctrl_d;
    end

    assign load_upper  = ctrl_q.load_upper;
    assign jump        = ctrl_q.jump;
    assign jal         = ctrl_q.jal;
    assign reg_write   = ctrl_q.reg_write;
    assign mem_to_reg  = ctrl_q.mem_to_reg;
    assign mem_write   = ctrl_q.mem_write;
    assign alu_control = ctrl_q.alu_control;
    assign alu_src     = ctrl_q.alu_src;
    assign reg_dst     = ctrl_q.reg_dst;
    assign branch      = ctrl_q.branch;
    assign bcu_control = ctrl_q.bcu_control;
    assign syscall     = ctrl_q.syscall;
    assign move_hi_lo  = ctrl_q.move_hi_lo;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed vectors against hand-computed control words.
module tb_control_unit;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       stall = 1'b0;
    logic       flush = 1'b0;
    logic [5:0] op_code = '0;
    logic [5:0] funct_code = '0;
    logic [4:0] rt = '0;
    logic       load_upper, jal, reg_write, mem_to_reg, mem_write, alu_src, reg_dst, branch, syscall;
    logic [1:0] jump, move_hi_lo;
    logic [4:0] alu_control;
    logic [3:0] bcu_control;
    int total = 0;
    int bad = 0;

    control_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .flush       (flush),
        .op_code     (op_code),
        .funct_code  (funct_code),
        .rt          (rt),
        .load_upper  (load_upper),
        .jump        (jump),
        .jal         (jal),
        .reg_write   (reg_write),
        .mem_to_reg  (mem_to_reg),
        .mem_write   (mem_write),
        .alu_control (alu_control),
        .alu_src     (alu_src),
        .reg_dst     (reg_dst),
        .branch      (branch),
        .bcu_control (bcu_control),
        .syscall     (syscall),
        .move_hi_lo  (move_hi_lo)
    );

    always #5 clk = ~clk;

    // field order: lu jump jal rw m2r mw alu src dst br bcu sc mhl
    function automatic logic [21:0] w(input logic lu, input logic [1:0] jmp, input logic jl,
            input logic rw, input logic m2r, input logic mw, input logic [4:0] alu,
            input logic src, input logic dst, input logic br, input logic [3:0] bcu,
            input logic sc, input logic [1:0] mhl);
        return {lu, jmp, jl, rw, m2r, mw, alu, src, dst, br, bcu, sc, mhl};
    endfunction

    task automatic chk(input string tag, input logic [21:0] exp);
        logic [21:0] obs;
        obs = {load_upper, jump, jal, reg_write, mem_to_reg, mem_write, alu_control,
               alu_src, reg_dst, branch, bcu_control, syscall, move_hi_lo};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] r,
            input logic s, input logic f);
        op_code = op; funct_code = fn; rt = r; stall = s; flush = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [21:0] nop;
        nop = '0;
        #3 chk("reset", nop);
        @(negedge clk) rst_n = 1'b1;
        step(6'b001001, 6'b101010, 5'd7, 0, 0); chk("addiu", w(0,0,0,1,0,0,5'd0,1,0,0,0,0,0));
        step(6'b000011, 6'd0, 5'd0, 0, 0);      chk("jal", w(0,2'b01,1,1,0,0,5'd0,0,0,0,0,0,0));
        step(6'b000000, 6'b001000, 5'd0, 0, 0); chk("jr", w(0,2'b10,0,0,0,0,5'd0,0,0,0,0,0,0));
        step(6'b100011, 6'd0, 5'd0, 0, 0);      chk("lw", w(0,0,0,1,1,0,5'd0,1,0,0,0,0,0));
        step(6'b101011, 6'd0, 5'd0, 0, 0);      chk("sw", w(0,0,0,0,0,1,5'd0,1,0,0,0,0,0));
        step(6'b001111, 6'd0, 5'd0, 0, 0);      chk("lui", w(1,0,0,1,0,0,5'd0,1,0,0,0,0,0));
        step(6'b000000, 6'b100001, 5'd0, 1, 0); chk("stall_hold", w(1,0,0,1,0,0,5'd0,1,0,0,0,0,0));
        step(6'b000000, 6'b100001, 5'd0, 1, 1); chk("flush_over_stall", nop);
        step(6'b000000, 6'b100001, 5'd0, 0, 0); chk("addu", w(0,0,0,1,0,0,5'd0,0,1,0,0,0,0));
        step(6'b000000, 6'b101011, 5'd0, 0, 0); chk("sltu", w(0,0,0,1,0,0,5'd7,0,1,0,0,0,0));
        step(6'b000100, 6'd0, 5'd0, 0, 0);      chk("beq", w(0,0,0,0,0,0,5'd1,0,0,1,4'd1,0,0));
        step(6'b000101, 6'd0, 5'd0, 0, 0);      chk("bne", w(0,0,0,0,0,0,5'd1,0,0,1,4'd2,0,0));
        step(6'b000001, 6'd0, 5'b00000, 0, 0);  chk("bltz", w(0,0,0,0,0,0,5'd0,0,0,1,4'd3,0,0));
        step(6'b000001, 6'd0, 5'b00001, 0, 0);  chk("bgez", w(0,0,0,0,0,0,5'd0,0,0,1,4'd4,0,0));
        step(6'b000001, 6'd0, 5'b00010, 0, 0);  chk("regimm_bad_rt", nop);
        step(6'b000110, 6'd0, 5'd0, 0, 0);      chk("blez", w(0,0,0,0,0,0,5'd0,0,0,1,4'd5,0,0));
        step(6'b000111, 6'd0, 5'd0, 0, 0);      chk("bgtz", w(0,0,0,0,0,0,5'd0,0,0,1,4'd6,0,0));
        step(6'b111111, 6'd0, 5'd0, 0, 0);      chk("op_3f", nop);
        step(6'b000000, 6'b000011, 5'd0, 0, 0); chk("sra", w(0,0,0,1,0,0,5'd10,0,1,0,0,0,0));
        step(6'b000000, 6'b001100, 5'd0, 0, 0); chk("syscall", w(0,0,0,0,0,0,5'd0,0,0,0,0,1,0));
`ifdef CONTROL_UNIT_HILO_EN
        step(6'b000000, 6'b011000, 5'd0, 0, 0); chk("mult", w(0,0,0,0,0,0,5'd11,0,0,0,0,0,2'b11));
        step(6'b000000, 6'b010000, 5'd0, 0, 0); chk("mfhi", w(0,0,0,1,0,0,5'd0,0,1,0,0,0,2'b01));
        step(6'b000000, 6'b010010, 5'd0, 0, 0); chk("mflo", w(0,0,0,1,0,0,5'd0,0,1,0,0,0,2'b10));
`else
        step(6'b000000, 6'b011000, 5'd0, 0, 0); chk("mult_off", nop);
        step(6'b000000, 6'b100001, 5'd0, 0, 0); chk("addu2", w(0,0,0,1,0,0,5'd0,0,1,0,0,0,0));
        step(6'b000000, 6'b010000, 5'd0, 0, 0); chk("mfhi_off", nop);
`endif
        step(6'b000000, 6'b111111, 5'd0, 0, 0); chk("bad_funct", nop);
        step(6'b001101, 6'b001000, 5'd1, 0, 0); chk("ori", w(0,0,0,1,0,0,5'd3,1,0,0,0,0,0));
        #2 rst_n = 1'b0;
        #1 chk("async_reset", nop);
        step(6'b001001, 6'd0, 5'd0, 1, 1);
        chk("reset_over_stall_flush", nop);
        #2 rst_n = 1'b1;
        step(6'b001001, 6'd0, 5'd0, 0, 0); chk("first_after_reset", w(0,0,0,1,0,0,5'd0,1,0,0,0,0,0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
